// File: rtl/snu_board_pkg.sv
// Shared definitions for the SNU_Board switch input stage.
// Optional feature macro used by the files that import this package:
// SNU_SW_TOGGLE_EN (adds latched toggle outputs).
package snu_board_pkg;

   // Number of switch channels feeding SW1..SW6
   localparam int N_SW           = 6;

   // Default stability counter width and acceptance threshold (1 ms at 50 MHz)
   localparam int CNT_W_DEF      = 16;
   localparam int STABLE_CNT_DEF = 50000;

   // Per-channel debounce state: IDLE while synchronised level matches the
   // debounced level, COUNT while a differing level is being timed
   typedef enum logic {
      IDLE  = 1'b0,
      COUNT = 1'b1
   } ch_state_e;

endpackage

// File: rtl/snu_debounce_ch.sv
// One switch channel: two-flop synchroniser, stability counter FSM,
// registered rise/fall pulses and, with SNU_SW_TOGGLE_EN defined, a toggle
// bit that flips on the edge that clears each rise pulse.
module snu_debounce_ch
   import snu_board_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int STABLE_CNT = STABLE_CNT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic sw_raw,
   output logic sw_db,
   output logic sw_rise,
   output logic sw_fall
`ifdef SNU_SW_TOGGLE_EN
   ,
   output logic sw_tgl
`endif
);

   // Last counter value before a differing level is accepted
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_r;
   logic             sync2_r;
   logic [CNT_W-1:0] cnt_r;
   ch_state_e        state_r;
   logic             db_r;
   logic             rise_r;
   logic             fall_r;
   logic             differ_s;
   logic             at_last_s;

   assign differ_s  = sync2_r ^ db_r;
   assign at_last_s = (cnt_r == CNT_LAST);

   // Bring the asynchronous raw level into the clock domain
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= sw_raw;
         sync2_r <= sync1_r;
      end
   end

   // Debounce FSM: time a differing level, accept it after STABLE_CNT edges
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         db_r    <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         rise_r <= 1'b0;
         fall_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (differ_s) begin
                  if (at_last_s) begin
                     // Threshold of one: accept immediately
                     db_r    <= sync2_r;
                     rise_r  <= sync2_r;
                     fall_r  <= ~sync2_r;
                     cnt_r   <= CNT_ZERO;
                     state_r <= IDLE;
                  end else begin
                     cnt_r   <= cnt_r + CNT_ONE;
                     state_r <= COUNT;
                  end
               end else begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= IDLE;
               end
            end
            COUNT: begin
               if (!differ_s) begin
                  // Bounced back to the debounced level: restart
                  cnt_r   <= CNT_ZERO;
                  state_r <= IDLE;
               end else if (at_last_s) begin
                  db_r    <= sync2_r;
                  rise_r  <= sync2_r;
                  fall_r  <= ~sync2_r;
                  cnt_r   <= CNT_ZERO;
                  state_r <= IDLE;
               end else begin
                  cnt_r   <= cnt_r + CNT_ONE;
                  state_r <= COUNT;
               end
            end
            default: begin
               cnt_r   <= CNT_ZERO;
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign sw_db   = db_r;
   assign sw_rise = rise_r;
   assign sw_fall = fall_r;

`ifdef SNU_SW_TOGGLE_EN
   logic tgl_r;

   // Latch push-button presses: flip on the edge that clears each rise pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         tgl_r <= 1'b0;
      end else begin
         tgl_r <= tgl_r ^ rise_r;
      end
   end

   assign sw_tgl = tgl_r;
`endif

endmodule

// File: rtl/snu_switch_debounce.sv
// SNU_Board switch input stage: N_SW independent debounce channels whose
// debounced levels drive SW1..SW6 (SW_DB[5] = SW1). SW_CHANGED flags any
// rise or fall pulse in the current cycle.
// Optional feature: define SNU_SW_TOGGLE_EN to add the SW_TGL outputs.
module snu_switch_debounce
   import snu_board_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int STABLE_CNT = STABLE_CNT_DEF
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [N_SW-1:0] SW_RAW,
   output logic [N_SW-1:0] SW_DB,
   output logic [N_SW-1:0] SW_RISE,
   output logic [N_SW-1:0] SW_FALL,
`ifdef SNU_SW_TOGGLE_EN
   output logic [N_SW-1:0] SW_TGL,
`endif
   output logic            SW_CHANGED
);

   genvar gi;
   generate
      for (gi = 0; gi < N_SW; gi++) begin : g_ch
         snu_debounce_ch #(
            .CNT_W      (CNT_W),
            .STABLE_CNT (STABLE_CNT)
         ) u_ch (
            .clk     (CLK),
            .rst     (RST),
            .sw_raw  (SW_RAW[gi]),
            .sw_db   (SW_DB[gi]),
            .sw_rise (SW_RISE[gi]),
`ifdef SNU_SW_TOGGLE_EN
            .sw_tgl  (SW_TGL[gi]),
`endif
            .sw_fall (SW_FALL[gi])
         );
      end
   endgenerate

   // Pulses are already registered, so the OR is clean in the same cycle
   assign SW_CHANGED = (|SW_RISE) | (|SW_FALL);

endmodule

// File: tb/tb_snu_switch_debounce.sv
// Scoreboard bench for snu_switch_debounce with STABLE_CNT=4, CNT_W=3.
// Expected debounce events are queued with their due edge when the raw
// inputs are driven and retired when that edge is reached.
module tb_snu_switch_debounce;

   logic       clk;
   logic       rst;
   logic [5:0] sw_raw;
   logic [5:0] sw_db;
   logic [5:0] sw_rise;
   logic [5:0] sw_fall;
   logic       sw_changed;
`ifdef SNU_SW_TOGGLE_EN
   logic [5:0] sw_tgl;
`endif

   typedef struct {
      int         cyc;
      logic [5:0] rise;
      logic [5:0] fall;
   } evt_t;

   evt_t       sb_q[$];
   int         n_chk;
   int         n_fail;
   int         edge_n;
   logic [5:0] exp_db;
   logic [5:0] exp_tgl;
   logic [5:0] prev_rise;

   snu_switch_debounce #(
      .CNT_W      (3),
      .STABLE_CNT (4)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .SW_RAW     (sw_raw),
      .SW_DB      (sw_db),
      .SW_RISE    (sw_rise),
      .SW_FALL    (sw_fall),
`ifdef SNU_SW_TOGGLE_EN
      .SW_TGL     (sw_tgl),
`endif
      .SW_CHANGED (sw_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [5:0] act, input logic [5:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", tag, act, exp);
      end
   endtask

   // Advance one edge, retire due events and compare every output
   task automatic tick();
      logic       rst_at_edge;
      logic [5:0] er;
      logic [5:0] ef;
      evt_t       keep[$];
      rst_at_edge = rst;
      @(posedge clk);
      #1;
      edge_n++;
      er = 6'b0;
      ef = 6'b0;
      if (rst_at_edge) begin
         sb_q.delete();
         exp_db  = 6'b0;
         exp_tgl = 6'b0;
      end else begin
         exp_tgl = exp_tgl ^ prev_rise;
         foreach (sb_q[i]) begin
            if (sb_q[i].cyc == edge_n) begin
               er = er | sb_q[i].rise;
               ef = ef | sb_q[i].fall;
            end else begin
               keep.push_back(sb_q[i]);
            end
         end
         sb_q   = keep;
         exp_db = (exp_db | er) & ~ef;
      end
      prev_rise = er;
      check($sformatf("db@%0d", edge_n), sw_db, exp_db);
      check($sformatf("rise@%0d", edge_n), sw_rise, er);
      check($sformatf("fall@%0d", edge_n), sw_fall, ef);
      check($sformatf("changed@%0d", edge_n), {5'b0, sw_changed}, {5'b0, ((|er) | (|ef))});
`ifdef SNU_SW_TOGGLE_EN
      check($sformatf("tgl@%0d", edge_n), sw_tgl, exp_tgl);
`endif
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Drive a new clean raw level and queue its debounced result
   task automatic drive(input logic [5:0] v);
      evt_t e;
      e.cyc  = edge_n + 6;
      e.rise = v & ~sw_raw;
      e.fall = ~v & sw_raw;
      if ((e.rise | e.fall) != 6'b0) sb_q.push_back(e);
      sw_raw = v;
   endtask

   initial begin
      evt_t e;
      n_chk     = 0;
      n_fail    = 0;
      edge_n    = 0;
      exp_db    = 6'b0;
      exp_tgl   = 6'b0;
      prev_rise = 6'b0;
      rst       = 1'b1;
      sw_raw    = 6'b111111;

      // 1: all high through reset; rise on every channel 6 edges after release
      ticks(3);
      rst    = 1'b0;
      e.cyc  = edge_n + 6;
      e.rise = sw_raw;
      e.fall = 6'b0;
      sb_q.push_back(e);
      ticks(10);

      // 2: bounce on ch0 (first bring it low)
      drive(sw_raw & ~6'b000001);
      ticks(10);
      sw_raw[0] = 1'b1;
      ticks(3);
      sw_raw[0] = 1'b0;
      ticks(1);
      drive(sw_raw | 6'b000001);
      ticks(10);

      // 3: fall on ch3
      drive(sw_raw & ~6'b001000);
      ticks(10);

      // 4: simultaneous rise ch1 and fall ch5
      drive(sw_raw & ~6'b000010);
      ticks(10);
      drive((sw_raw | 6'b000010) & ~6'b100000);
      ticks(10);

      // 5: reset in the middle of a ch2 count
      drive(sw_raw & ~6'b000100);
      ticks(10);
      sw_raw[2] = 1'b1;
      ticks(3);
      rst = 1'b1;
      tick();
      rst    = 1'b0;
      e.cyc  = edge_n + 6;
      e.rise = sw_raw;
      e.fall = 6'b0;
      sb_q.push_back(e);
      ticks(10);

      // 6: three presses on ch4 (toggle tracked when the feature is built)
      drive(sw_raw & ~6'b010000);
      ticks(10);
      for (int p = 0; p < 3; p++) begin
         drive(sw_raw | 6'b010000);
         ticks(10);
         drive(sw_raw & ~6'b010000);
         ticks(10);
      end

      check("sb_empty", 6'(sb_q.size()), 6'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
